spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI slave receive stage that sits directly downstream of the link handshake in the FPGA datapath. Once the handshake reports the link up, it samples the master's SCLK/MOSI/CS_N in the system clock domain and deserialises SPI mode 0, MSB-first words. It delivers each word on a valid/ready interface to the message consumer and flags overrun and truncated-frame conditions.

## Interface
- DATA_W, 8, bits per SPI word.
- SYNC_STAGES, 2, synchroniser depth for sclk/mosi/cs_n; legal range 2..3.

- clk  in  1  system clock; must be at least 4x SCLK frequency.
- rst  in  1  reset, asynchronous, active-low.
- link_up  in  1  handshake established (handshake READY state); synchronous to clk.
- sclk  in  1  SPI clock from master; asynchronous.
- mosi  in  1  SPI data from master; asynchronous.
- cs_n  in  1  SPI chip select, active-low; asynchronous.
- miso  out  1  SPI data to master (see Configuration).
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- overrun  out  1  sticky; a completed word was dropped.
- ovr_clr  in  1  clears overrun.
- frame_err  out  1  one-cycle pulse; cs_n rose mid-word.

## Operation
- sclk, mosi, cs_n each pass through SYNC_STAGES flops; one extra register on synced sclk gives rise/fall detect.
- FSM states:
  - IDLE: link_up=0; ignore SPI pins. Go to ARMED when link_up=1.
  - ARMED: wait for synced cs_n=0, then go to SHIFT with bit_cnt=0.
  - SHIFT: on each synced sclk rise, shift mosi into shreg LSB (MSB first on the wire) and increment bit_cnt.
- Word completion: the rise with bit_cnt==DATA_W-1 completes a word; bit_cnt wraps to 0 and the FSM stays in SHIFT for back-to-back words.
- Synced cs_n=1 in SHIFT:
  - bit_cnt≠0: discard partial word, pulse frame_err, go to ARMED.
  - bit_cnt==0: go to ARMED without error.
- link_up=0 in any state: go to IDLE, discard partial word, no frame_err. Any held rx_data/rx_valid is kept until consumed.
- Output register on word completion:
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=0: drop the new word, keep the old rx_data, set overrun.
- Handshake: transfer occurs when rx_valid & rx_ready; rx_valid clears the next cycle unless a new word loads in that same cycle.
- rx_data is stable while rx_valid=1 and rx_ready=0.
- overrun clears on ovr_clr. If a set and ovr_clr coincide, set wins.
- bit_cnt width is clog2(DATA_W). No other arithmetic.

## Timing
- Reset values: state=IDLE, shreg=0, bit_cnt=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0, miso=0.
- Latency: call clk edge E the first edge at which the SYNC_STAGES-th sclk flop... more precisely, E is the first clk edge sampling sclk=1 at the first synchroniser input. The bit is captured at E+SYNC_STAGES+1.
- rx_valid rises at E+SYNC_STAGES+2 for the final bit of a word.
- frame_err pulses SYNC_STAGES+2 cycles after cs_n rise is first sampled.
- Back-to-back words with rx_ready held at 1 never cause overrun.
- Assertion of rst mid-word returns every output to its reset value immediately. Deassertion is synchronised externally.

## Configuration
- SPI_RX_MISO_ECHO_EN defined:
  - miso shifts out the most recently completed word (including one dropped by overrun), MSB first.
  - Next bit is driven on each synced sclk fall while in SHIFT. Bit DATA_W-1 is presented on entry to SHIFT.
  - The first frame after reset echoes all zeros.
- SPI_RX_MISO_ECHO_EN undefined: miso is constant 0 and no echo register exists.

## Test plan
- Reset, link_up=1, send 0xA5 with cs_n low, rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5 at E+4 (SYNC_STAGES=2); overrun=0.
- Send 0x3C then 0xC3 in one cs_n frame, rx_ready=0 -> rx_data=0x3C held, overrun=1 after second word; ovr_clr -> overrun=0.
- Raise cs_n after 5 bits of 0xFF, then send 0x12 -> frame_err single pulse, next word rx_data=0x12.
- link_up=0 during SHIFT after 3 bits -> state IDLE, no rx_valid, no frame_err; sclk toggles ignored until link_up=1.
- Assert rst while rx_valid=1 -> rx_valid=0, rx_data=0, overrun=0 within the same cycle.
- SPI_RX_MISO_ECHO_EN: send 0x5A then 0x00 -> miso bits during second word read 0x5A MSB first; without the macro miso stays 0.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode 0 slave receiver: synchronises sclk/mosi/cs_n into clk and deserialises MSB-first words onto a valid/ready port.
// Optional echo of the last completed word on miso is enabled by defining SPI_RX_MISO_ECHO_EN.
//
// state | meaning
// IDLE  | link down, SPI pins ignored
// ARMED | link up, waiting for chip select low
// SHIFT | chip select low, shifting bits in on sclk rise
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              frame_err
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   rise_q;
    logic                   mosi_q;
    logic                   cs_d;
    logic [DATA_W-1:0]      shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   word_done;
    logic                   frame_pend;

    // Edge pulse and data are registered once more so the FSM acts on a clean, aligned pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            rise_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            rise_q    <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            word_done  <= 1'b0;
            frame_pend <= 1'b0;
        end else begin
            word_done  <= 1'b0;
            frame_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (link_up) state <= ARMED;
                end
                ARMED: begin
                    if (!link_up) begin
                        state <= IDLE;
                    end else if (!cs_d) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!link_up) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (cs_d) begin
                        state      <= ARMED;
                        frame_pend <= (bit_cnt != '0);
                        bit_cnt    <= '0;
                    end else if (rise_q) begin
                        shreg <= {shreg[DATA_W-2:0], mosi_q};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A word arriving while the previous one is unconsumed is dropped; overrun set beats ovr_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_pend;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (word_done && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_MISO_ECHO_EN
    logic              fall_q;
    logic [DATA_W-1:0] echo_word;
    logic [DATA_W-1:0] echo_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fall_q    <= 1'b0;
            echo_word <= '0;
            echo_sh   <= '0;
            miso      <= 1'b0;
        end else begin
            fall_q <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
            if (word_done) echo_word <= shreg;
            // The fall after a word boundary starts the echo over from the newest word.
            if (state == ARMED && link_up && !cs_d) begin
                miso    <= echo_word[DATA_W-1];
                echo_sh <= {echo_word[DATA_W-2:0], 1'b0};
            end else if (state == SHIFT && link_up && !cs_d && fall_q) begin
                if (bit_cnt == '0) begin
                    miso    <= echo_word[DATA_W-1];
                    echo_sh <= {echo_word[DATA_W-2:0], 1'b0};
                end else begin
                    miso    <= echo_sh[DATA_W-1];
                    echo_sh <= {echo_sh[DATA_W-2:0], 1'b0};
                end
            end
        end
    end
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus random frames against a word-level model.
module tb_spi_slave_rx;
    localparam int HP = 8;

`ifdef SPI_RX_MISO_ECHO_EN
    localparam logic [7:0] ECHO_EXP = 8'h5A;
`else
    localparam logic [7:0] ECHO_EXP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       link_up = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;
    logic       ovr_clr = 1'b0;
    logic       frame_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fe_cnt   = 0;
    bit ovr_seen = 1'b0;
    logic [7:0] got_q[$];

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .link_up(link_up), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .ovr_clr(ovr_clr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Handshake/pulse monitor, sampled mid-cycle after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ovr_seen = 1'b1;
        end
    end

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        mosi = b;
        repeat (HP) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (HP) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_word(input logic [7:0] w, output logic [7:0] m);
        for (int i = 7; i >= 0; i--) spi_bit(w[i], m[i]);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
        chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        link_up = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] w;
        logic       m;
        logic [5:0] lat_v;
        logic [7:0] data_at4;
        w = 8'hA5;
        rx_ready = 1'b1;
        got_q.delete();
        cs_low();
        for (int i = 7; i >= 1; i--) spi_bit(w[i], m);
        @(negedge clk);
        mosi = w[0];
        repeat (HP) @(negedge clk);
        sclk = 1'b1;
        data_at4 = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            lat_v[k] = rx_valid;
            if (k == 4) data_at4 = rx_data;
        end
        repeat (HP - 3) @(negedge clk);
        sclk = 1'b0;
        cs_high();
        chk_cnt++; if (lat_v !== 6'b010000) $display("FAIL basic_latency: rx_valid by cycle %b expected 010000", lat_v); else pass_cnt++;
        chk_cnt++; if (data_at4 !== 8'hA5) $display("FAIL basic_data: got %h expected a5", data_at4); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b expected 0", overrun); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== 1) $display("FAIL basic_count: got %0d expected 1", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [7:0] m, a, b;
        rx_ready = 1'b0;
        got_q.delete();
        cs_low();
        spi_word(8'h3C, m);
        spi_word(8'hC3, m);
        cs_high();
        chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", rx_valid); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h3C) $display("FAIL ovr_data_held: got %h expected 3c", rx_data); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else pass_cnt++;
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        @(negedge clk);
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else pass_cnt++;
        rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
        @(negedge clk);
        chk_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) $display("FAIL ovr_consumed: got %0d words expected one 3c", got_q.size()); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_valid_drop: got %b expected 0", rx_valid); else pass_cnt++;
        // ovr_clr held through the drop: the set must still be visible for a cycle.
        a = 8'($urandom);
        b = 8'($urandom);
        ovr_seen = 1'b0;
        ovr_clr = 1'b1;
        cs_low();
        spi_word(a, m);
        spi_word(b, m);
        cs_high();
        ovr_clr = 1'b0;
        @(negedge clk);
        chk_cnt++; if (ovr_seen !== 1'b1) $display("FAIL ovr_set_wins: seen %b expected 1", ovr_seen); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr_after: got %b expected 0", overrun); else pass_cnt++;
        chk_cnt++; if (rx_data !== a) $display("FAIL ovr_first_kept: got %h expected %h", rx_data, a); else pass_cnt++;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_err();
        logic       m;
        logic [7:0] mw;
        logic [5:0] fe_v;
        rx_ready = 1'b1;
        got_q.delete();
        fe_cnt = 0;
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            fe_v[k] = frame_err;
        end
        repeat (2 * HP) @(negedge clk);
        chk_cnt++; if (fe_v !== 6'b010000) $display("FAIL fe_timing: frame_err by cycle %b expected 010000", fe_v); else pass_cnt++;
        chk_cnt++; if (fe_cnt !== 1) $display("FAIL fe_single: got %0d pulses expected 1", fe_cnt); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== 0) $display("FAIL fe_no_word: got %0d words expected 0", got_q.size()); else pass_cnt++;
        cs_low();
        spi_word(8'h12, mw);
        cs_high();
        chk_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'h12) $display("FAIL fe_next_word: got %0d words expected one 12", got_q.size()); else pass_cnt++;
        chk_cnt++; if (fe_cnt !== 1) $display("FAIL fe_clean_frame: got %0d pulses expected 1", fe_cnt); else pass_cnt++;
    endtask

    task automatic test_link_drop();
        logic       m;
        logic [7:0] w, mw;
        rx_ready = 1'b1;
        got_q.delete();
        fe_cnt = 0;
        cs_low();
        for (int i = 0; i < 3; i++) spi_bit(1'($urandom), m);
        @(negedge clk);
        link_up = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 9; i++) spi_bit(1'($urandom), m);
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HP) @(negedge clk);
        chk_cnt++; if (got_q.size() !== 0) $display("FAIL link_no_word: got %0d words expected 0", got_q.size()); else pass_cnt++;
        chk_cnt++; if (fe_cnt !== 0) $display("FAIL link_no_fe: got %0d pulses expected 0", fe_cnt); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL link_valid: got %b expected 0", rx_valid); else pass_cnt++;
        link_up = 1'b1;
        repeat (4) @(negedge clk);
        w = 8'($urandom);
        cs_low();
        spi_word(w, mw);
        cs_high();
        chk_cnt++; if (got_q.size() !== 1 || got_q[0] !== w) $display("FAIL link_resume: got %0d words expected one %h", got_q.size(), w); else pass_cnt++;
        chk_cnt++; if (fe_cnt !== 0) $display("FAIL link_resume_fe: got %0d pulses expected 0", fe_cnt); else pass_cnt++;
    endtask

    task automatic test_rst();
        logic [7:0] mw;
        rx_ready = 1'b0;
        cs_low();
        spi_word(8'($urandom), mw);
        spi_word(8'($urandom), mw);
        cs_high();
        chk_cnt++; if (rx_valid !== 1'b1 || overrun !== 1'b1) $display("FAIL rst_setup: valid %b overrun %b expected 1 1", rx_valid, overrun); else pass_cnt++;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_async_valid: got %b expected 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_async_data: got %h expected 00", rx_data); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL rst_async_overrun: got %b expected 0", overrun); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_echo();
        logic [7:0] s1, s2;
        rx_ready = 1'b1;
        got_q.delete();
        cs_low();
        spi_word(8'h5A, s1);
        spi_word(8'h00, s2);
        cs_high();
        chk_cnt++; if (s1 !== 8'h00) $display("FAIL echo_first_frame: got %h expected 00", s1); else pass_cnt++;
        chk_cnt++; if (s2 !== ECHO_EXP) $display("FAIL echo_second_word: got %h expected %h", s2, ECHO_EXP); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== 2) $display("FAIL echo_words: got %0d expected 2", got_q.size()); else pass_cnt++;
    endtask

    // Model: every complete group of 8 bits in a frame is one delivered word; a leftover group is one frame error.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] w, mw;
        logic       m;
        int         exp_fe;
        int         nw, np;
        rx_ready = 1'b1;
        got_q.delete();
        fe_cnt = 0;
        exp_fe = 0;
        for (int f = 0; f < 8; f++) begin
            nw = $urandom_range(1, 3);
            np = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
            cs_low();
            for (int j = 0; j < nw; j++) begin
                w = 8'($urandom);
                exp_q.push_back(w);
                spi_word(w, mw);
            end
            for (int j = 0; j < np; j++) spi_bit(1'($urandom), m);
            if (np != 0) exp_fe++;
            cs_high();
        end
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (fe_cnt !== exp_fe) $display("FAIL rand_fe: got %0d expected %0d", fe_cnt, exp_fe); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b expected 0", overrun); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_link_drop();
        test_rst();
        test_echo();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
